// File: rtl/frame_repeater_axis.sv
`timescale 1ns/1ps
// Store-and-forward AXIS frame repeater: captures one frame, replays it num_repeats times (0 -> 1).
// Latency: first replayed beat valid 2 cycles after the input tlast handshake; one beat/cycle after.
// Backpressure: slave side stalls for the whole replay; master side uses a two-stage prefetch for full rate.
module frame_repeater_axis #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int MAX_FRAME_BEATS        = 1024,
    parameter int NUM_FRAME_SIZE         = 4
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic [NUM_FRAME_SIZE-1:0]             num_repeats,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  overflow
);

    localparam int DW = C_M00_AXIS_TDATA_WIDTH;
    localparam int SW = C_M00_AXIS_TDATA_WIDTH / 8;
    localparam int AW = $clog2(MAX_FRAME_BEATS);
    localparam int LW = AW + 1;
    localparam int EW = DW + SW;

    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;

    logic [0:0]                state, state_nxt;
    logic [LW-1:0]             wr_ptr, len, rd_addr;
    logic [NUM_FRAME_SIZE-1:0] rep_target, rd_copy;
    logic                      rd_done;

    logic [EW-1:0]             mem [MAX_FRAME_BEATS];
    logic [EW-1:0]             ram_q;
    logic                      ram_vld, ram_last, ram_final;
    logic                      out_final;

    logic s_acc, in_room, out_adv, out_hs, final_hs;
    logic rd_issue, rd_last, rd_final;

    assign s_acc    = (state == ST_FILL) && s00_axis_tready && s00_axis_tvalid;
    assign in_room  = (wr_ptr < LW'(MAX_FRAME_BEATS));
    assign out_adv  = !m00_axis_tvalid || m00_axis_tready;
    assign out_hs   = m00_axis_tvalid && m00_axis_tready;
    assign final_hs = out_hs && out_final;

    // A read is issued only when the RAM output stage is empty or will drain this cycle,
    // so nothing is ever overwritten and full rate survives arbitrary tready patterns.
    assign rd_issue = (state == ST_REPLAY) && !rd_done && (!ram_vld || out_adv);
    assign rd_last  = (rd_addr == len - LW'(1));
    assign rd_final = rd_last && (rd_copy == rep_target - NUM_FRAME_SIZE'(1));

    always_comb begin
        state_nxt = state;
        if (state == ST_FILL && s_acc && s00_axis_tlast)
            state_nxt = ST_REPLAY;
        else if (state == ST_REPLAY && final_hs)
            state_nxt = ST_FILL;
    end

    // Buffer: write port from the slave side, registered read feeding the prefetch stage.
    always_ff @(posedge s00_axis_aclk) begin
        if (s_acc && in_room)
            mem[wr_ptr[AW-1:0]] <= {s00_axis_tstrb, s00_axis_tdata};
        if (rd_issue)
            ram_q <= mem[rd_addr[AW-1:0]];
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state           <= ST_FILL;
            s00_axis_tready <= 1'b0;
            wr_ptr          <= '0;
            len             <= '0;
            rep_target      <= NUM_FRAME_SIZE'(1);
            overflow        <= 1'b0;
            rd_addr         <= '0;
            rd_copy         <= '0;
            rd_done         <= 1'b0;
            ram_vld         <= 1'b0;
            ram_last        <= 1'b0;
            ram_final       <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            out_final       <= 1'b0;
        end else begin
            state           <= state_nxt;
            s00_axis_tready <= (state_nxt == ST_FILL);

            if (s_acc) begin
                // wr_ptr is zero only on the first beat of a frame, so that is where the count is sampled
                if (wr_ptr == '0)
                    rep_target <= (num_repeats == '0) ? NUM_FRAME_SIZE'(1) : num_repeats;
                if (in_room)
                    wr_ptr <= wr_ptr + LW'(1);
                else
                    overflow <= 1'b1;
                if (s00_axis_tlast) begin
                    len     <= in_room ? wr_ptr + LW'(1) : LW'(MAX_FRAME_BEATS);
                    rd_addr <= '0;
                    rd_copy <= '0;
                    rd_done <= 1'b0;
                end
            end

            if (rd_issue) begin
                if (rd_last) begin
                    rd_addr <= '0;
                    rd_copy <= rd_copy + NUM_FRAME_SIZE'(1);
                    if (rd_final)
                        rd_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + LW'(1);
                end
            end

            if (rd_issue) begin
                ram_vld   <= 1'b1;
                ram_last  <= rd_last;
                ram_final <= rd_final;
            end else if (ram_vld && out_adv) begin
                ram_vld <= 1'b0;
            end

            if (out_adv) begin
                m00_axis_tvalid <= ram_vld;
                if (ram_vld) begin
                    m00_axis_tdata <= ram_q[DW-1:0];
                    m00_axis_tstrb <= ram_q[EW-1 -: SW];
                    m00_axis_tlast <= ram_last;
                    out_final      <= ram_final;
                end else begin
                    m00_axis_tlast <= 1'b0;
                    out_final      <= 1'b0;
                end
            end

            if (final_hs)
                wr_ptr <= '0;
        end
    end

endmodule

// File: tb/tb_frame_repeater_axis.sv
`timescale 1ns/1ps
// Directed bench for frame_repeater_axis: table of frames plus hand-written reset and timing sequences.
module tb_frame_repeater_axis;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  num_repeats = 4'd1;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tready;
    logic        m_tready = 1'b1;
    logic        m_tvalid, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        overflow;

    frame_repeater_axis #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .MAX_FRAME_BEATS(8),
        .NUM_FRAME_SIZE(4)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .num_repeats(num_repeats),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready),
        .m00_axis_tready(m_tready),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tstrb(m_tstrb),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nbeats;
        logic [31:0] base;
        logic [3:0]  nrep;
        logic [3:0]  nrep_mid;
        bit          rand_rdy;
        int          exp_copies;
        int          exp_len;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    tlast_edge = 0;
    int    first_vld_cyc = -1;
    int    exp_total = 0;
    int    rdy_viol = 0;
    bit    rdy_rand = 1'b0;
    bit    in_replay = 1'b0;
    bit    chk_back = 1'b0;
    bit    stall_prev = 1'b0;
    bit    prev_vld = 1'b0;
    logic [36:0] held = '0;
    beat_t out_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: drives m_tready, captures handshaken beats, checks hold-while-stalled.
    always @(negedge clk) begin
        if (stall_prev)
            chk("hold_stable", {27'd0, m_tvalid, m_tlast, m_tstrb, m_tdata}, {27'd0, 1'b1, held});
        if (chk_back) begin
            chk("tready_after_replay", 64'(s_tready), 64'd1);
            chk_back = 1'b0;
        end
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_tvalid && !prev_vld && first_vld_cyc < 0)
            first_vld_cyc = cyc;
        if (in_replay && s_tready)
            rdy_viol++;
        if (m_tvalid && m_tready) begin
            out_q.push_back('{m_tdata, m_tstrb, m_tlast});
            if (in_replay && out_q.size() == exp_total) begin
                in_replay = 1'b0;
                chk_back  = 1'b1;
            end
        end
        stall_prev = m_tvalid && !m_tready;
        held       = {m_tlast, m_tstrb, m_tdata};
        prev_vld   = m_tvalid;
    end

    task automatic send_frame(input int n, input logic [31:0] base,
                              input logic [3:0] nrep, input logic [3:0] nrep_mid);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            num_repeats = (i == 0) ? nrep : nrep_mid;
            s_tvalid = 1'b1;
            s_tdata  = base + 32'(i);
            s_tstrb  = 4'(i + 1);
            s_tlast  = (i == n - 1);
            while (!s_tready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                chk("send_timeout", 64'(t), 64'd0);
                break;
            end
            if (i == n - 1)
                tlast_edge = cyc + 1;
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        num_repeats = nrep_mid;
    endtask

    task automatic run_vec(input vec_t v);
        int wd = 0;
        int k = 0;
        out_q.delete();
        rdy_viol      = 0;
        rdy_rand      = v.rand_rdy;
        exp_total     = v.exp_copies * v.exp_len;
        first_vld_cyc = -1;
        send_frame(v.nbeats, v.base, v.nrep, v.nrep_mid);
        in_replay = 1'b1;
        while (out_q.size() < exp_total && wd < 500) begin
            @(negedge clk);
            wd++;
        end
        if (wd >= 500) chk("replay_timeout", 64'(wd), 64'd0);
        repeat (6) @(negedge clk);
        in_replay = 1'b0;
        chk("beat_count", 64'(out_q.size()), 64'(exp_total));
        for (int c = 0; c < v.exp_copies; c++) begin
            for (int b = 0; b < v.exp_len; b++) begin
                if (k < out_q.size())
                    chk("beat", {27'd0, out_q[k].last, out_q[k].strb, out_q[k].data},
                        {27'd0, 1'(b == v.exp_len - 1), 4'(b + 1), v.base + 32'(b)});
                k++;
            end
        end
        chk("first_latency", 64'(first_vld_cyc - tlast_edge), 64'd2);
        chk("s_tready_low_in_replay", 64'(rdy_viol), 64'd0);
        chk("overflow", 64'(overflow), 64'(v.exp_ovf));
        rdy_rand = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        //         nbeats base     nrep  mid   rnd copies len ovf
        vecs[0] = '{4,  32'h10, 4'd3, 4'd3, 1'b0, 3, 4, 1'b0};
        vecs[1] = '{2,  32'h0A, 4'd0, 4'd0, 1'b0, 1, 2, 1'b0};
        vecs[2] = '{4,  32'h10, 4'd3, 4'd3, 1'b1, 3, 4, 1'b0};
        vecs[3] = '{1,  32'h55, 4'd2, 4'd2, 1'b0, 2, 1, 1'b0};
        vecs[4] = '{4,  32'h20, 4'd2, 4'd5, 1'b0, 2, 4, 1'b0};
        vecs[5] = '{3,  32'h30, 4'd5, 4'd5, 1'b1, 5, 3, 1'b0};
        vecs[6] = '{10, 32'h00, 4'd1, 4'd1, 1'b0, 1, 8, 1'b1};
        vecs[7] = '{3,  32'h40, 4'd2, 4'd2, 1'b0, 2, 3, 1'b1};
        vecs[8] = '{8,  32'h80, 4'd1, 4'd1, 1'b1, 1, 8, 1'b1};

        #2;
        chk("rst_outputs", {26'd0, s_tready, m_tvalid, m_tlast, m_tstrb, overflow, m_tdata},
            64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("tready_before_edge", 64'(s_tready), 64'd0);
        @(negedge clk);
        chk("tready_first_edge", 64'(s_tready), 64'd1);

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i]);

        // Reset during the second copy of a 3x replay
        begin
            int wd = 0;
            out_q.delete();
            exp_total = 1000;
            send_frame(4, 32'h60, 4'd3, 4'd3);
            while (out_q.size() < 5 && wd < 200) begin
                @(negedge clk);
                wd++;
            end
            chk("mid_replay_reached", 64'(out_q.size() >= 5), 64'd1);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_async_tvalid", 64'(m_tvalid), 64'd0);
            chk("rst_async_tready", 64'(s_tready), 64'd0);
            chk("rst_async_overflow", 64'(overflow), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            out_q.delete();
            @(negedge clk);
            chk("rst_tready_release", 64'(s_tready), 64'd1);
            repeat (5) @(negedge clk);
            chk("no_partial_output", 64'(out_q.size()), 64'd0);
            run_vec('{3, 32'h70, 4'd2, 4'd2, 1'b0, 2, 3, 1'b0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
